// File: rtl/nanci_sort_sched.sv
// Shearsort schedule controller for a SQRT_N x SQRT_N Nanci PE mesh: load, alternating
// row/column odd-even transposition phases, compute window, done. Abort via NANCI_SCHED_ABORT_EN.
module nanci_sort_sched #(
  parameter int LOG_SQRT_N     = 2,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_load,
  output logic [1:0] o_mode,
  output logic       o_parity,
  output logic       o_commit,
  output logic       o_compute,
  output logic       o_done
);

  localparam int SQRT_N = 1 << LOG_SQRT_N;
  localparam logic [CNT_WIDTH-1:0] SORT_LAST  = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STEP_LAST  = CNT_WIDTH'(SQRT_N - 1);
  localparam logic [CNT_WIDTH-1:0] COMP_LAST  = CNT_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ROUND_LAST = CNT_WIDTH'(LOG_SQRT_N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROW, S_COL, S_COMPUTE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] round_q, round_d;
  logic [CNT_WIDTH-1:0] step_q, step_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;

  logic       busy_q, busy_d;
  logic       load_q, load_d;
  logic [1:0] mode_q, mode_d;
  logic       parity_q, parity_d;
  logic       commit_q, commit_d;
  logic       compute_q, compute_d;
  logic       done_q, done_d;

  logic abort_req;
`ifdef NANCI_SCHED_ABORT_EN
  assign abort_req = i_abort;
`else
  logic unused_abort;
  assign unused_abort = i_abort;
  assign abort_req    = 1'b0;
`endif

  logic sorting_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    step_d  = step_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      S_IDLE: begin
        round_d = '0;
        step_d  = '0;
        cyc_d   = '0;
        if (i_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ROW;
        round_d = '0;
        step_d  = '0;
        cyc_d   = '0;
      end
      S_ROW, S_COL: begin
        if (cyc_q == SORT_LAST) begin
          cyc_d = '0;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (state_q == S_COL) begin
              state_d = S_ROW;
              round_d = round_q + 1'b1;
            end else if (round_q == ROUND_LAST) begin
              state_d = S_COMPUTE;
            end else begin
              state_d = S_COL;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cyc_q == COMP_LAST) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && state_q != S_IDLE) begin
      state_d = S_IDLE;
      round_d = '0;
      step_d  = '0;
      cyc_d   = '0;
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    sorting_d = (state_d == S_ROW) || (state_d == S_COL);
    busy_d    = (state_d != S_IDLE);
    load_d    = (state_d == S_LOAD);
    parity_d  = sorting_d && step_d[0];
    commit_d  = sorting_d && (cyc_d == SORT_LAST);
    compute_d = (state_d == S_COMPUTE);
    done_d    = (state_d == S_DONE);
    unique case (state_d)
      S_ROW:     mode_d = 2'b01;
      S_COL:     mode_d = 2'b10;
      S_COMPUTE: mode_d = 2'b11;
      default:   mode_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      step_q    <= '0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      mode_q    <= 2'b00;
      parity_q  <= 1'b0;
      commit_q  <= 1'b0;
      compute_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      step_q    <= step_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      mode_q    <= mode_d;
      parity_q  <= parity_d;
      commit_q  <= commit_d;
      compute_q <= compute_d;
      done_q    <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_load    = load_q;
  assign o_mode    = mode_q;
  assign o_parity  = parity_q;
  assign o_commit  = commit_q;
  assign o_compute = compute_q;
  assign o_done    = done_q;

endmodule
